lbm_frame_buffer: RTL
=====================

// Module: lbm_frame_buffer
// PURPOSE
// - Ping-pong frame store between the LBM solver and the AXIS streaming read controller.
// - Accepts one 144-bit pixel beat per handshake from the solver and writes it into one of two banks.
// - Each bank holds DEPTH pixels x 9 directions.
// - A full bank is exposed to the read controller via chunk_transfer_ready and read by address.
// - The solver fills the other bank meanwhile; solver stalls only when both banks are full.
// PARAMETERS
// - DATA_WIDTH     16    width of one direction value
// - DEPTH          2500  pixels per frame (50x50 lattice); DEPTH <= 2**ADDRESS_WIDTH
// - ADDRESS_WIDTH  12    pixel address width
// PORTS
// - m00_axis_aclk      in   1    clock
// - m00_axis_aresetn   in   1    reset, asynchronous, active-low
// - in_valid           in   1    solver beat valid
// - in_ready           out  1    beat accepted when in_valid & in_ready
// - in_data            in   144  {null,n,ne,e,se,s,sw,w,nw}, 16 b each, null in MSBs
// - read_addr          in   12   pixel address from read controller
// - frame_read_done    in   1    1-cycle pulse: read controller finished current frame
// - chunk_transfer_ready  out  1  read bank is full and may be streamed
// - null1,n1,ne1,e1,se1,s1,sw1,w1,nw1  out  16 each  registered read data
// BEHAVIOUR
// - Storage: banks 0/1, DEPTH x 144 each; full[1:0] flags; wr_bank and rd_bank 1-bit pointers.
// - Reset: full=00, wr_bank=rd_bank=0, wr_addr=0.
// - Reset output values: direction outputs=0, chunk_transfer_ready=0, in_ready=0 while reset is low.
// - Write FSM, state FILL:
//   - in_ready=1.
//   - Each accepted beat writes bank[wr_bank][wr_addr], then wr_addr++.
//   - On the beat accepted at wr_addr==DEPTH-1: set full[wr_bank], wr_addr<=0, toggle wr_bank.
//   - If full[new wr_bank] is still set after that update, go to WAIT_BANK.
// - Write FSM, state WAIT_BANK:
//   - in_ready=0.
//   - Return to FILL the cycle after full[wr_bank] clears; in_ready is high in that cycle.
// - Read FSM, state R_IDLE:
//   - chunk_transfer_ready=0.
//   - If full[rd_bank]=1, go to R_STREAM next cycle.
// - Read FSM, state R_STREAM:
//   - chunk_transfer_ready=1 (registered).
//   - On frame_read_done: clear full[rd_bank], toggle rd_bank, return to R_IDLE.
//   - chunk_transfer_ready is low for at least 1 cycle between frames.
// - frame_read_done while in R_IDLE is ignored: no flag change.
// - Read port latency: 1 cycle.
//   - Outputs at cycle t+1 = bank[rd_bank][read_addr(t)], split into 9 fields.
//   - read_addr >= DEPTH returns all-zero fields.
//   - Reads are valid in any state; the read bank is never the bank being written.
// - Simultaneous events:
//   - Frame completion on wr_bank and frame_read_done on rd_bank in the same cycle both take effect.
//   - full is updated as (full | set) & ~clr; set and clr always target different banks.
//   - With one bank full and one filling, completing the fill while the same-cycle frame_read_done frees the other bank -> no WAIT_BANK entry.
// - Wrap: wr_addr wraps DEPTH-1 -> 0 only on frame completion; never counts above DEPTH-1.
// - Reset mid-frame: the partial frame is discarded and both banks are treated as empty.
//   - RAM contents are not cleared.
// - No drop path: the solver is always back-pressured, never overrun.
// STRUCTURE
// - Package lbm_pkg:
//   - DATA_WIDTH, NDIR=9, DEPTH, ADDRESS_WIDTH.
//   - Direction field offsets: NW=0 .. NULL=8, in 16-bit slices.
//   - Write/read FSM state localparams.
// - Sub-module lbm_bank_ram: simple dual-port RAM, 1 write port, 1 registered read port, DEPTH x 144.
//   - Instantiated twice; the top level holds the FSMs, pointers, flags and output mux.
// TESTING
// - Fill: 2500 beats, in_data=pixel index replicated in each field.
//   -> chunk_transfer_ready=1 two cycles after last beat.
//   -> read_addr=7 yields all fields = 7 one cycle later.
// - Ping-pong: stream frame 0 and frame 1 back-to-back, no frame_read_done.
//   -> in_ready=0 from beat 5000 on.
//   -> pulse frame_read_done: rd_bank=1, in_ready=1 on the next cycle.
// - Simultaneous: last beat of frame 1 in the same cycle as frame_read_done for frame 0.
//   -> full=10, no WAIT_BANK, chunk_transfer_ready low 1 cycle then high.
// - Out of range: read_addr=2500 and read_addr=4095 -> all outputs 0 next cycle.
// - Spurious done: frame_read_done in R_IDLE with full=00 -> no state or flag change.
// - Reset at beat 1200: assert m00_axis_aresetn low.
//   -> chunk_transfer_ready=0, outputs 0.
//   -> after release, 2500 new beats are needed before chunk_transfer_ready=1.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared constants, direction field offsets and FSM state types for the LBM frame buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbm_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int NDIR          = 9;
  localparam int DEPTH         = 2500;
  localparam int ADDRESS_WIDTH = 12;
  localparam int PIX_WIDTH     = DATA_WIDTH * NDIR;

  // Direction slot index inside a pixel beat; slot k occupies bits [16k +: 16].
  localparam int DIR_NW   = 0;
  localparam int DIR_W    = 1;
  localparam int DIR_SW   = 2;
  localparam int DIR_S    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_E    = 5;
  localparam int DIR_NE   = 6;
  localparam int DIR_N    = 7;
  localparam int DIR_NULL = 8;

  typedef enum logic {
    W_FILL      = 1'b0,
    W_WAIT_BANK = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/lbm_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears one cycle after raddr is presented.
// Backpressure: none; the caller keeps addresses in range and decides when to write.
module lbm_bank_ram
  import lbm_pkg::*;
#(
  parameter int WIDTH  = PIX_WIDTH,
  parameter int DEPTH_P = DEPTH,
  parameter int AW     = ADDRESS_WIDTH
) (
  input  logic             m00_axis_aclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH_P];

  // Write port: storage is deliberately not reset.
  always_ff @(posedge m00_axis_aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge m00_axis_aclk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbm_frame_buffer.sv
// Ping-pong frame store: solver fills one bank while the read controller streams the other.
// Latency: read data 1 cycle after read_addr; chunk_transfer_ready 2 cycles after a frame's last beat.
// Backpressure: in_ready drops only while both banks hold unread frames; nothing is ever dropped.
module lbm_frame_buffer
  import lbm_pkg::*;
(
  input  logic                      m00_axis_aclk,
  input  logic                      m00_axis_aresetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_WIDTH-1:0]      in_data,
  input  logic [ADDRESS_WIDTH-1:0]  read_addr,
  input  logic                      frame_read_done,
  output logic                      chunk_transfer_ready,
  output logic [DATA_WIDTH-1:0]     null1,
  output logic [DATA_WIDTH-1:0]     n1,
  output logic [DATA_WIDTH-1:0]     ne1,
  output logic [DATA_WIDTH-1:0]     e1,
  output logic [DATA_WIDTH-1:0]     se1,
  output logic [DATA_WIDTH-1:0]     s1,
  output logic [DATA_WIDTH-1:0]     sw1,
  output logic [DATA_WIDTH-1:0]     w1,
  output logic [DATA_WIDTH-1:0]     nw1
);

  wr_state_t                wr_state, wr_state_nxt;
  rd_state_t                rd_state, rd_state_nxt;
  logic [1:0]               full, full_nxt, full_set, full_clr;
  logic                     wr_bank, rd_bank;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic                     accept, last_beat, done_ok;
  logic                     addr_ok, addr_ok_q, rd_sel_q;
  logic [ADDRESS_WIDTH-1:0] ram_raddr;
  logic [PIX_WIDTH-1:0]     rdata0, rdata1, rd_pix;

  // in_ready is forced low while reset is held, even though the FSM sits in FILL.
  assign in_ready  = (wr_state == W_FILL) && m00_axis_aresetn;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (wr_addr == ADDRESS_WIDTH'(DEPTH - 1));
  // A done pulse only counts while a frame is actually being streamed.
  assign done_ok   = frame_read_done && (rd_state == R_STREAM);

  // Flag update: the set (write side) and clear (read side) always hit different banks.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (last_beat) full_set[wr_bank] = 1'b1;
    if (done_ok)   full_clr[rd_bank] = 1'b1;
    full_nxt = (full | full_set) & ~full_clr;
  end

  // Write FSM next state, judged on the post-update flags so a same-cycle release avoids a stall.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_FILL:      if (last_beat && full_nxt[~wr_bank]) wr_state_nxt = W_WAIT_BANK;
      W_WAIT_BANK: if (!full_nxt[wr_bank])              wr_state_nxt = W_FILL;
      default:     wr_state_nxt = W_FILL;
    endcase
  end

  // Read FSM next state; leaving STREAM always passes through IDLE for at least one cycle.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:   if (full[rd_bank])  rd_state_nxt = R_STREAM;
      R_STREAM: if (frame_read_done) rd_state_nxt = R_IDLE;
      default:  rd_state_nxt = R_IDLE;
    endcase
  end

  assign chunk_transfer_ready = (rd_state == R_STREAM);

  // State, flags, pointers and write address.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_state <= W_FILL;
      rd_state <= R_IDLE;
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_addr  <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      full     <= full_nxt;
      if (accept) begin
        if (last_beat) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (done_ok) rd_bank <= ~rd_bank;
    end
  end

  // Out-of-range addresses never reach the RAM; they read back as zero instead.
  assign addr_ok   = {1'b0, read_addr} < (ADDRESS_WIDTH + 1)'(DEPTH);
  assign ram_raddr = addr_ok ? read_addr : '0;

  lbm_bank_ram u_bank0 (
    .m00_axis_aclk (m00_axis_aclk),
    .we            (accept && !wr_bank),
    .waddr         (wr_addr),
    .wdata         (in_data),
    .raddr         (ram_raddr),
    .rdata         (rdata0)
  );

  lbm_bank_ram u_bank1 (
    .m00_axis_aclk (m00_axis_aclk),
    .we            (accept && wr_bank),
    .waddr         (wr_addr),
    .wdata         (in_data),
    .raddr         (ram_raddr),
    .rdata         (rdata1)
  );

  // Capture bank select and range check alongside the RAM read so the mux matches the data.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      addr_ok_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      addr_ok_q <= addr_ok;
      rd_sel_q  <= rd_bank;
    end
  end

  assign rd_pix = !addr_ok_q ? '0 : (rd_sel_q ? rdata1 : rdata0);

  assign nw1   = rd_pix[DIR_NW   * DATA_WIDTH +: DATA_WIDTH];
  assign w1    = rd_pix[DIR_W    * DATA_WIDTH +: DATA_WIDTH];
  assign sw1   = rd_pix[DIR_SW   * DATA_WIDTH +: DATA_WIDTH];
  assign s1    = rd_pix[DIR_S    * DATA_WIDTH +: DATA_WIDTH];
  assign se1   = rd_pix[DIR_SE   * DATA_WIDTH +: DATA_WIDTH];
  assign e1    = rd_pix[DIR_E    * DATA_WIDTH +: DATA_WIDTH];
  assign ne1   = rd_pix[DIR_NE   * DATA_WIDTH +: DATA_WIDTH];
  assign n1    = rd_pix[DIR_N    * DATA_WIDTH +: DATA_WIDTH];
  assign null1 = rd_pix[DIR_NULL * DATA_WIDTH +: DATA_WIDTH];

endmodule
